vga_timing_gen: RTL and testbench

//  Parametrised, two-mode VGA timing generator; successor to the fixed-mode timing controller.

---
 rtl/vga_timing_gen_if.sv | 11 +
 rtl/vga_timing_gen.sv | 76 +++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: run-time controls and decoded timing outputs of the VGA timing generator.
interface vga_timing_gen_if #(parameter int CNT_W = 11, parameter int FCNT_W = 16) ();
  logic enable, mode_sel;
  logic [CNT_W-1:0] hcount, vcount;
  logic hblnk, vblnk, hsync, vsync, de, line_start, frame_start, mode_active;
  logic [FCNT_W-1:0] frame_cnt;
  modport master (input enable, mode_sel, output hcount, vcount, hblnk, vblnk, hsync, vsync, de,
                  line_start, frame_start, mode_active, frame_cnt);
  modport slave (output enable, mode_sel, input hcount, vcount, hblnk, vblnk, hsync, vsync, de,
                 line_start, frame_start, mode_active, frame_cnt);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-mode VGA timing generator with frame-boundary mode switching.
module vga_timing_gen #(
  parameter int CNT_W = 11, parameter int FCNT_W = 16,
  parameter int M0_H_ACT = 800, parameter int M0_H_FP = 40, parameter int M0_H_SYNC = 128, parameter int M0_H_BP = 88,
  parameter int M0_V_ACT = 600, parameter int M0_V_FP = 1, parameter int M0_V_SYNC = 4, parameter int M0_V_BP = 23,
  parameter bit M0_HS_POL = 1'b1, parameter bit M0_VS_POL = 1'b1,
  parameter int M1_H_ACT = 1024, parameter int M1_H_FP = 24, parameter int M1_H_SYNC = 136, parameter int M1_H_BP = 160,
  parameter int M1_V_ACT = 768, parameter int M1_V_FP = 3, parameter int M1_V_SYNC = 6, parameter int M1_V_BP = 29,
  parameter bit M1_HS_POL = 1'b0, parameter bit M1_VS_POL = 1'b0
) (
  input logic clk,
  input logic rst,
  vga_timing_gen_if.master bus
);
  typedef struct packed {
    logic [CNT_W-1:0] ha, hss, hse, ht, va, vss, vse, vt;
    logic hp, vp;
  } tim_t;
  // sync ranges and totals are stored as inclusive last positions
  localparam tim_t T0 = '{
    ha: CNT_W'(M0_H_ACT), hss: CNT_W'(M0_H_ACT + M0_H_FP), hse: CNT_W'(M0_H_ACT + M0_H_FP + M0_H_SYNC - 1),
    ht: CNT_W'(M0_H_ACT + M0_H_FP + M0_H_SYNC + M0_H_BP - 1),
    va: CNT_W'(M0_V_ACT), vss: CNT_W'(M0_V_ACT + M0_V_FP), vse: CNT_W'(M0_V_ACT + M0_V_FP + M0_V_SYNC - 1),
    vt: CNT_W'(M0_V_ACT + M0_V_FP + M0_V_SYNC + M0_V_BP - 1),
    hp: M0_HS_POL, vp: M0_VS_POL};
  localparam tim_t T1 = '{
    ha: CNT_W'(M1_H_ACT), hss: CNT_W'(M1_H_ACT + M1_H_FP), hse: CNT_W'(M1_H_ACT + M1_H_FP + M1_H_SYNC - 1),
    ht: CNT_W'(M1_H_ACT + M1_H_FP + M1_H_SYNC + M1_H_BP - 1),
    va: CNT_W'(M1_V_ACT), vss: CNT_W'(M1_V_ACT + M1_V_FP), vse: CNT_W'(M1_V_ACT + M1_V_FP + M1_V_SYNC - 1),
    vt: CNT_W'(M1_V_ACT + M1_V_FP + M1_V_SYNC + M1_V_BP - 1),
    hp: M1_HS_POL, vp: M1_VS_POL};
  tim_t cur, nt;
  logic h_end, v_end, f_wrap, n_mode;
  logic [CNT_W-1:0] n_h, n_v;
  // limits come from the running mode; decode of the next position uses the mode it will be in
  always_comb begin
    cur = bus.mode_active ? T1 : T0;
    h_end = bus.hcount == cur.ht;
    v_end = bus.vcount == cur.vt;
    f_wrap = h_end && v_end;
    n_mode = f_wrap ? bus.mode_sel : bus.mode_active;
    nt = n_mode ? T1 : T0;
    n_h = h_end ? '0 : bus.hcount + CNT_W'(1);
    n_v = h_end ? (v_end ? '0 : bus.vcount + CNT_W'(1)) : bus.vcount;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.hcount <= '0;
      bus.vcount <= '0;
      bus.hblnk <= 1'b0;
      bus.vblnk <= 1'b0;
      bus.hsync <= !M0_HS_POL;
      bus.vsync <= !M0_VS_POL;
      bus.de <= 1'b0;
      bus.line_start <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.mode_active <= 1'b0;
      bus.frame_cnt <= '0;
    end else if (bus.enable) begin
      bus.hcount <= n_h;
      bus.vcount <= n_v;
      bus.hblnk <= n_h >= nt.ha;
      bus.vblnk <= n_v >= nt.va;
      bus.hsync <= (n_h >= nt.hss && n_h <= nt.hse) ? nt.hp : !nt.hp;
      bus.vsync <= (n_v >= nt.vss && n_v <= nt.vse) ? nt.vp : !nt.vp;
      bus.de <= n_h < nt.ha && n_v < nt.va;
      bus.line_start <= n_h == '0;
      bus.frame_start <= n_h == '0 && n_v == '0;
      bus.mode_active <= n_mode;
      bus.frame_cnt <= bus.frame_cnt + FCNT_W'(f_wrap);
    end else begin
      bus.line_start <= 1'b0;
      bus.frame_start <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized and directed checks of vga_timing_gen against a linear-position model.
module tb_vga_timing_gen;
  localparam int HA[2] = '{16, 20};
  localparam int HF[2] = '{2, 1};
  localparam int HS[2] = '{3, 4};
  localparam int HB[2] = '{4, 3};
  localparam int VA[2] = '{10, 12};
  localparam int VF[2] = '{1, 2};
  localparam int VS[2] = '{2, 1};
  localparam int VB[2] = '{3, 2};
  localparam bit HP[2] = '{1'b1, 1'b0};
  localparam bit VP[2] = '{1'b1, 1'b0};
  logic clk = 1'b0, rst = 1'b0;
  int checks = 0, passes = 0;
  vga_timing_gen_if #(.CNT_W(8), .FCNT_W(2)) bus ();
  vga_timing_gen #(
    .CNT_W(8), .FCNT_W(2),
    .M0_H_ACT(16), .M0_H_FP(2), .M0_H_SYNC(3), .M0_H_BP(4),
    .M0_V_ACT(10), .M0_V_FP(1), .M0_V_SYNC(2), .M0_V_BP(3), .M0_HS_POL(1'b1), .M0_VS_POL(1'b1),
    .M1_H_ACT(20), .M1_H_FP(1), .M1_H_SYNC(4), .M1_H_BP(3),
    .M1_V_ACT(12), .M1_V_FP(2), .M1_V_SYNC(1), .M1_V_BP(2), .M1_HS_POL(1'b0), .M1_VS_POL(1'b0)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // model: a pixel index within the frame plus the mode that frame is drawn in
  int mpos, mf;
  logic mm, mls, mfs, fresh;
  function automatic int htot(input logic m);
    return HA[m] + HF[m] + HS[m] + HB[m];
  endfunction
  function automatic int ftot(input logic m);
    return htot(m) * (VA[m] + VF[m] + VS[m] + VB[m]);
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mpos <= 0; mf <= 0; mm <= 1'b0; mls <= 1'b0; mfs <= 1'b0; fresh <= 1'b1;
    end else if (bus.enable) begin
      fresh <= 1'b0;
      mpos <= (mpos + 1) % ftot(mm);
      mls <= ((mpos + 1) % htot(mm)) == 0;
      mfs <= (mpos + 1) == ftot(mm);
      if (mpos + 1 == ftot(mm)) begin
        mm <= bus.mode_sel;
        mf <= (mf + 1) % 4;
      end
    end else begin
      mls <= 1'b0; mfs <= 1'b0;
    end
  end
  function automatic logic [25:0] want();
    int h, v;
    logic hb, vb, hs, vs;
    h = mpos % htot(mm);
    v = mpos / htot(mm);
    hb = h >= HA[mm];
    vb = v >= VA[mm];
    hs = (h >= HA[mm] + HF[mm] && h < HA[mm] + HF[mm] + HS[mm]) ? HP[mm] : !HP[mm];
    vs = (v >= VA[mm] + VF[mm] && v < VA[mm] + VF[mm] + VS[mm]) ? VP[mm] : !VP[mm];
    return {8'(h), 8'(v), hb, vb, hs, vs, !fresh && !hb && !vb, mls, mfs, mm, 2'(mf)};
  endfunction
  function automatic logic [25:0] got();
    return {bus.hcount, bus.vcount, bus.hblnk, bus.vblnk, bus.hsync, bus.vsync, bus.de,
            bus.line_start, bus.frame_start, bus.mode_active, bus.frame_cnt};
  endfunction
  task automatic test_reset();
    bus.enable = 1'b0; bus.mode_sel = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (got() !== 26'd0) $display("FAIL reset_values got=%h want=%h", got(), 26'd0); else passes++;
    checks++;
    if (got() !== want()) $display("FAIL reset_model got=%h want=%h", got(), want()); else passes++;
    rst = 1'b1; bus.enable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.hcount !== 8'd1 || bus.frame_start !== 1'b0) $display("FAIL first_clk hcount=%0d fs=%b want 1,0", bus.hcount, bus.frame_start); else passes++;
  endtask
  task automatic test_mode0();
    int t = 0, f1 = -1, f2 = -1, de_n = 0, ls_n = 0;
    logic [1:0] fc2 = 2'd0;
    for (int i = 0; i < 1000 && f2 < 0; i++) begin
      @(negedge clk); t++;
      checks++;
      if (got() !== want()) $display("FAIL mode0_cycle got=%h want=%h", got(), want()); else passes++;
      if (bus.frame_start) begin
        if (f1 < 0) f1 = t; else begin f2 = t; fc2 = bus.frame_cnt; end
      end
      if (f1 >= 0 && f2 < 0) begin de_n += int'(bus.de); ls_n += int'(bus.line_start); end
    end
    checks++;
    if (f2 - f1 !== 400) $display("FAIL frame_period got=%0d want=400", f2 - f1); else passes++;
    checks++;
    if (de_n !== 160) $display("FAIL de_count got=%0d want=160", de_n); else passes++;
    checks++;
    if (ls_n !== 16) $display("FAIL lines_per_frame got=%0d want=16", ls_n); else passes++;
    checks++;
    if (fc2 !== 2'd2) $display("FAIL frame_cnt_two got=%0d want=2", fc2); else passes++;
  endtask
  task automatic test_switch();
    bit hit = 0;
    int len = 0;
    repeat (37) @(negedge clk);
    bus.mode_sel = 1'b1;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      checks++;
      if (got() !== want()) $display("FAIL switch_cycle got=%h want=%h", got(), want()); else passes++;
      if (bus.frame_start) begin
        hit = 1;
        checks++;
        if ({bus.hcount, bus.vcount, bus.mode_active, bus.hsync, bus.vsync} !== {16'd0, 3'b111})
          $display("FAIL switch_wrap h=%0d v=%0d mode=%b hs=%b vs=%b want 0,0,1,1,1", bus.hcount, bus.vcount, bus.mode_active, bus.hsync, bus.vsync);
        else passes++;
      end else begin
        checks++;
        if (bus.mode_active !== 1'b0) $display("FAIL switch_early mode=%b want 0", bus.mode_active); else passes++;
      end
    end
    checks++;
    if (!hit) $display("FAIL switch_timeout got=no_wrap want=wrap"); else passes++;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); len++;
      if (bus.line_start) break;
    end
    checks++;
    if (len !== 28) $display("FAIL m1_line_len got=%0d want=28", len); else passes++;
  endtask
  task automatic test_freeze();
    bit hit = 0;
    logic [25:0] s;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(negedge clk);
      hit = int'(bus.hcount) == HA[mm] - 1;
    end
    checks++;
    if (!hit) $display("FAIL freeze_wait got=no_position want=%0d", HA[mm] - 1); else passes++;
    bus.enable = 1'b0;
    s = got();
    repeat (50) begin
      @(negedge clk);
      checks++;
      if (got() !== (s & ~26'h18)) $display("FAIL freeze_hold got=%h want=%h", got(), s & ~26'h18); else passes++;
    end
    bus.enable = 1'b1;
    @(negedge clk);
    checks++;
    if (int'(bus.hcount) !== HA[mm] || bus.hblnk !== 1'b1) $display("FAIL resume h=%0d hb=%b want %0d,1", bus.hcount, bus.hblnk, HA[mm]); else passes++;
    checks++;
    if (got() !== want()) $display("FAIL resume_model got=%h want=%h", got(), want()); else passes++;
  endtask
  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.enable = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 99) == 0) bus.mode_sel = 1'($urandom);
      @(negedge clk);
      checks++;
      if (got() !== want()) $display("FAIL random_cycle got=%h want=%h", got(), want()); else passes++;
    end
  endtask
  task automatic test_async_reset();
    bit hit = 0;
    bus.enable = 1'b1; bus.mode_sel = 1'b1;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      hit = bus.mode_active && bus.hcount == 8'd10 && bus.vcount == 8'd5;
    end
    checks++;
    if (!hit) $display("FAIL areset_wait got=no_position want=m1_10_5"); else passes++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (got() !== 26'd0) $display("FAIL async_reset got=%h want=%h", got(), 26'd0); else passes++;
    checks++;
    if (got() !== want()) $display("FAIL async_reset_model got=%h want=%h", got(), want()); else passes++;
    bus.mode_sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_fcnt_wrap();
    int exp_fc[5] = '{1, 2, 3, 0, 1};
    for (int f = 0; f < 5; f++) begin
      bit hit = 0;
      for (int i = 0; i < 600 && !hit; i++) begin
        @(negedge clk);
        hit = bus.frame_start;
      end
      checks++;
      if (!hit || int'(bus.frame_cnt) !== exp_fc[f]) $display("FAIL fcnt_wrap[%0d] got=%0d want=%0d", f, bus.frame_cnt, exp_fc[f]); else passes++;
    end
  endtask
  initial begin
    test_reset();
    test_mode0();
    test_switch();
    test_freeze();
    test_random();
    test_async_reset();
    test_fcnt_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
